// File: rtl/bubble_pkg.sv
// Shared constants and FSM state type for the bubble position tracker.
package bubble_pkg;

    localparam int unsigned LOOP_LENGTH_DEF = 2053;
    localparam int unsigned BOOT_LENGTH_DEF = 1024;
    localparam int unsigned ADDR_W_DEF      = 12;
    localparam int unsigned CHANNELS_DEF    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StReady,
        StShift
    } state_e;

endpackage

// File: rtl/bubble_position_tracker_if.sv
// Page-buffer fetch bus: the tracker is master (req/addr), the buffer is slave (ack/data).
interface bubble_position_tracker_if
    import bubble_pkg::*;
#(
    parameter int unsigned AddrW = ADDR_W_DEF,
    parameter int unsigned ChanW = CHANNELS_DEF
) ();

    logic             read_req;
    logic [AddrW-1:0] read_addr;
    logic             read_ack;
    logic [ChanW-1:0] read_data;

    modport master (
        output read_req,
        output read_addr,
        input  read_ack,
        input  read_data
    );

    modport slave (
        input  read_req,
        input  read_addr,
        output read_ack,
        output read_data
    );

endinterface

// File: rtl/bubble_sync_edge.sv
// Two-flop synchroniser for one async pin, plus single-cycle rise/fall pulses.
module bubble_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], async_i};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/bubble_position_tracker.sv
// Tracks emulated bubble minor-loop position, fetches each latched position's word from the
// page buffer and presents it on the detector outputs inside the strobe/notice window.
module bubble_position_tracker
    import bubble_pkg::*;
#(
    parameter int unsigned LOOP_LENGTH = LOOP_LENGTH_DEF,
    parameter int unsigned BOOT_LENGTH = BOOT_LENGTH_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned CHANNELS    = CHANNELS_DEF
) (
    input  logic                master_clock,
    input  logic                reset,
    input  logic                position_change,
    input  logic                position_latch,
    input  logic                data_out_strobe,
    input  logic                data_out_notice,
    input  logic                bootloader_select,
    input  logic                coil_run,
    output logic [ADDR_W-1:0]   current_position,
    output logic [CHANNELS-1:0] bubble_out,
    output logic                busy,
    output logic                underrun,
    output logic                overrun,
    bubble_position_tracker_if.master rd
);

    localparam logic [ADDR_W-1:0] LoopLast = ADDR_W'(LOOP_LENGTH - 1);
    localparam logic [ADDR_W-1:0] BootLast = ADDR_W'(BOOT_LENGTH - 1);

    // Pin order: change, latch, strobe, notice, boot select, coil run.
    logic [5:0] pins, lvl, rise, fall;
    assign pins = {coil_run, bootloader_select, data_out_notice, data_out_strobe,
                   position_latch, position_change};

    for (genvar i = 0; i < 6; i++) begin : g_sync
        bubble_sync_edge u_sync (
            .clk_i   (master_clock),
            .rst_i   (reset),
            .async_i (pins[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    logic unused_edges;
    assign unused_edges = ^{rise[5:2], fall[5:4], fall[1:0], lvl[3:0]};

    logic pc_rise, latch_rise, strobe_fall, notice_fall;
    assign pc_rise     = rise[0];
    assign latch_rise  = rise[1];
    assign strobe_fall = fall[2];
    assign notice_fall = fall[3];

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d, len_last;
    logic [ADDR_W-1:0]   cur_pos_q, cur_pos_d, addr_q, addr_d;
    logic [CHANNELS-1:0] data_q, data_d, bubble_q, bubble_d;
    logic                req_q, req_d, busy_q, busy_d;
    logic                underrun_q, underrun_d, overrun_q, overrun_d;

    // >= rather than == so a counter stranded above a shorter length wraps on its next advance.
    always_comb begin
        len_last = lvl[4] ? BootLast : LoopLast;
        cnt_d    = cnt_q;
        if (pc_rise && lvl[5]) begin
            cnt_d = (cnt_q >= len_last) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_pos_d  = cur_pos_q;
        addr_d     = addr_q;
        req_d      = req_q;
        data_d     = data_q;
        bubble_d   = bubble_q;
        underrun_d = 1'b0;
        overrun_d  = latch_rise && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                bubble_d = '0;
                if (latch_rise) begin
                    cur_pos_d = cnt_d;
                    addr_d    = cnt_d;
                    req_d     = 1'b1;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                if (strobe_fall) begin
                    // An ack landing with the strobe still makes it onto the output.
                    req_d   = 1'b0;
                    state_d = StShift;
                    if (rd.read_ack) begin
                        bubble_d = rd.read_data;
                    end else begin
                        bubble_d   = '0;
                        underrun_d = 1'b1;
                    end
                end else if (rd.read_ack) begin
                    req_d   = 1'b0;
                    data_d  = rd.read_data;
                    state_d = StReady;
                end
            end
            StReady: begin
                if (strobe_fall) begin
                    bubble_d = notice_fall ? '0 : data_q;
                    state_d  = notice_fall ? StIdle : StShift;
                end
            end
            StShift: begin
                if (notice_fall) begin
                    bubble_d = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_pos_q  <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            data_q     <= '0;
            bubble_q   <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_pos_q  <= cur_pos_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            data_q     <= data_d;
            bubble_q   <= bubble_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign current_position = cur_pos_q;
    assign rd.read_req      = req_q;
    assign rd.read_addr     = addr_q;
    assign bubble_out       = bubble_q;
    assign busy             = busy_q;
    assign underrun         = underrun_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_bubble_position_tracker.sv
// Directed bench for bubble_position_tracker: counter wrap, length switch, fetch, under/overrun.
module tb_bubble_position_tracker;
    import bubble_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [3:0]                pins;  // change, latch, strobe, notice
    logic                      boot_sel, coil;
    logic [ADDR_W_DEF-1:0]     cur_pos;
    logic [CHANNELS_DEF-1:0]   bub;
    logic                      busy, und, ovr;
    int                        n_checks = 0;
    int                        n_fail   = 0;

    bubble_position_tracker_if bus ();

    bubble_position_tracker dut (
        .master_clock      (clk),
        .reset             (rst),
        .position_change   (pins[0]),
        .position_latch    (pins[1]),
        .data_out_strobe   (pins[2]),
        .data_out_notice   (pins[3]),
        .bootloader_select (boot_sel),
        .coil_run          (coil),
        .current_position  (cur_pos),
        .bubble_out        (bub),
        .busy              (busy),
        .underrun          (und),
        .overrun           (ovr),
        .rd                (bus.master)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The pin's event takes effect on the third edge after the toggle.
    task automatic edge_start(input int idx);
        pins[idx] = ~pins[idx];
        tick(3);
    endtask

    task automatic edge_end(input int idx);
        pins[idx] = ~pins[idx];
        tick(3);
    endtask

    task automatic pulse(input int idx);
        edge_start(idx);
        edge_end(idx);
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) pulse(0);
    endtask

    task automatic ack(input logic [3:0] d);
        bus.read_ack  = 1'b1;
        bus.read_data = d;
        tick(1);
        bus.read_ack  = 1'b0;
        bus.read_data = '0;
    endtask

    task automatic read_pos(input logic [11:0] exp, input string tag);
        edge_start(1);
        chk({tag, "_pos"}, 32'(cur_pos), 32'(exp));
        chk({tag, "_addr"}, 32'(bus.read_addr), 32'(exp));
        edge_end(1);
        ack(4'h0);
        pulse(2);
        pulse(3);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        pins          = 4'b1100;
        boot_sel      = 1'b0;
        coil          = 1'b1;
        bus.read_ack  = 1'b0;
        bus.read_data = '0;
        tick(3);
        chk("rst_req", 32'(bus.read_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bub", 32'(bub), 32'd0);
        chk("rst_pos", 32'(cur_pos), 32'd0);
        chk("rst_flags", 32'({und, ovr}), 32'd0);
        rst = 1'b0;
        tick(4);

        // Counter runs 0..2052 then wraps; frozen while coils are off.
        read_pos(12'd0, "cnt0");
        advance(2052);
        read_pos(12'd2052, "cnt2052");
        advance(1);
        read_pos(12'd0, "wrap");
        coil = 1'b0;
        tick(3);
        advance(5);
        read_pos(12'd0, "coil_off");
        coil = 1'b1;
        tick(3);

        // Shortening the loop while beyond its end wraps at the next advance.
        advance(1500);
        read_pos(12'd1500, "cnt1500");
        boot_sel = 1'b1;
        tick(3);
        advance(1);
        read_pos(12'd0, "boot_wrap");
        advance(1);
        read_pos(12'd1, "boot_next");
        boot_sel = 1'b0;
        tick(3);

        // Normal read at position 37.
        advance(36);
        edge_start(1);
        chk("nr_req", 32'(bus.read_req), 32'd1);
        chk("nr_addr", 32'(bus.read_addr), 32'd37);
        edge_end(1);
        tick(2);
        chk("nr_req_hold", 32'(bus.read_req), 32'd1);
        chk("nr_addr_hold", 32'(bus.read_addr), 32'd37);
        ack(4'b1010);
        chk("nr_req_drop", 32'(bus.read_req), 32'd0);
        chk("nr_busy", 32'(busy), 32'd1);
        chk("nr_bub_pre", 32'(bub), 32'd0);
        edge_start(2);
        chk("nr_bub", 32'(bub), 32'b1010);
        edge_end(2);
        edge_start(3);
        chk("nr_bub_off", 32'(bub), 32'd0);
        chk("nr_busy_off", 32'(busy), 32'd0);
        edge_end(3);

        // Underrun: strobe arrives before the ack.
        pulse(1);
        edge_start(2);
        chk("ur_pulse", 32'(und), 32'd1);
        chk("ur_req", 32'(bus.read_req), 32'd0);
        chk("ur_bub", 32'(bub), 32'd0);
        tick(1);
        chk("ur_pulse_end", 32'(und), 32'd0);
        edge_end(2);
        ack(4'hF);
        chk("ur_late_ack_bub", 32'(bub), 32'd0);
        chk("ur_late_ack_busy", 32'(busy), 32'd1);
        pulse(3);
        chk("ur_idle", 32'(busy), 32'd0);

        // Overrun: latch while READY leaves position untouched.
        pulse(1);
        ack(4'b0101);
        advance(1);
        edge_start(1);
        chk("or_pulse", 32'(ovr), 32'd1);
        chk("or_pos", 32'(cur_pos), 32'd37);
        tick(1);
        chk("or_pulse_end", 32'(ovr), 32'd0);
        edge_end(1);
        edge_start(2);
        chk("or_bub", 32'(bub), 32'b0101);
        edge_end(2);
        pulse(3);

        // Latch and advance in the same cycle at 99 latch 100.
        advance(61);
        pins[1:0] = 2'b11;
        tick(3);
        chk("sim_pos", 32'(cur_pos), 32'd100);
        chk("sim_addr", 32'(bus.read_addr), 32'd100);
        pins[1:0] = 2'b00;
        tick(3);
        ack(4'h0);
        pulse(2);
        pulse(3);

        // Strobe and notice together while READY: nothing shown, back to idle.
        pulse(1);
        ack(4'hF);
        chk("sn_busy", 32'(busy), 32'd1);
        pins[3:2] = 2'b00;
        tick(3);
        chk("sn_bub", 32'(bub), 32'd0);
        chk("sn_idle", 32'(busy), 32'd0);
        pins[3:2] = 2'b11;
        tick(3);

        // Reset during FETCH, then a stale ack.
        edge_start(1);
        chk("rf_req", 32'(bus.read_req), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("rf_req_drop", 32'(bus.read_req), 32'd0);
        chk("rf_busy", 32'(busy), 32'd0);
        pins[1] = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        ack(4'h7);
        chk("rf_stale_busy", 32'(busy), 32'd0);
        chk("rf_stale_req", 32'(bus.read_req), 32'd0);
        chk("rf_stale_bub", 32'(bub), 32'd0);
        read_pos(12'd0, "rf_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bubble_position_tracker.md
Name: bubble_position_tracker

Overview:
Downstream consumer of the bubble timing generator's status outputs, running on the 48 MHz master clock.
- Tracks the absolute minor-loop position of the emulated bubbles, modulo loop length; bootloop and main loop have different lengths.
- On each position latch it fetches that position's data word from the page buffer via a req/ack handshake.
- Presents the fetched bits on the detector output during the strobe window, flagging underrun and overrun.

Parameters:
LOOP_LENGTH, 2053, main minor-loop positions
BOOT_LENGTH, 1024, bootloop positions
ADDR_W, 12, position/address width; must satisfy 2^ADDR_W >= max(LOOP_LENGTH, BOOT_LENGTH)
CHANNELS, 4, data bits emitted per position

Ports:
master_clock  in  1  48 MHz system clock
reset  in  1  synchronous, active-high
position_change  in  1  async; rising edge = bubbles advanced one position
position_latch  in  1  async; rising edge = latch current position, start fetch
data_out_strobe  in  1  async; falling edge = drive data
data_out_notice  in  1  async; falling edge = end of output window
bootloader_select  in  1  async; 1 = bootloop length in force
coil_run  in  1  async; 1 = coils driving
current_position  out  ADDR_W  latched position
read_req  out  1  buffer fetch request
read_addr  out  ADDR_W  fetch address
read_ack  in  1  synchronous to master_clock; data valid
read_data  in  CHANNELS  fetched word
bubble_out  out  CHANNELS  detector data, active-high
busy  out  1  FSM not IDLE
underrun  out  1  one-cycle pulse
overrun  out  1  one-cycle pulse

Behaviour:
Clocking and reset:
- One clock, master_clock; reset is synchronous and active-high.
- Reset clears every register: counter, current_position, read_addr, bubble_out, read_req, busy, underrun, overrun, sync and edge registers. FSM goes to IDLE.
- Reset mid-fetch drops read_req on the next edge. A read_ack arriving after reset is ignored.

Input synchronisation:
- Each async input passes through a 2-FF synchroniser, then a previous-value register for edge detection.
- Edge pulses are one cycle wide, 3 cycles after the pin change.
- bootloader_select and coil_run are used as synchronised levels.

Position counter:
- Advances on a position_change rise only while synced coil_run = 1; otherwise it holds.
- LEN = bootloader_select ? BOOT_LENGTH : LOOP_LENGTH.
- Advance rule: if counter >= LEN-1, counter becomes 0; else counter + 1.
- The >= compare covers a length switch while counter >= new LEN: the wrap happens at the next advance.

Latch:
- On a position_latch rise in IDLE, current_position and read_addr take the counter's next value, so a same-cycle advance is included.
- FSM moves to FETCH.

FSM (IDLE, FETCH, READY, SHIFT):
- IDLE: busy = 0, bubble_out = 0.
- FETCH: read_req = 1 and read_addr stable until read_ack.
  - On read_ack, capture read_data, drop read_req on the same edge, go to READY.
  - If a strobe fall arrives first: drop read_req, pulse underrun, bubble_out = 0, go to SHIFT. A later read_ack is ignored.
- READY: on strobe fall, bubble_out takes the captured data; go to SHIFT.
- SHIFT: bubble_out is held. On notice fall, bubble_out = 0 and the FSM goes to IDLE.
- Strobe fall and notice fall in the same cycle while READY: bubble_out stays 0; go to IDLE.
- Latch rise in any state other than IDLE: ignored, overrun pulses, state unchanged.
- read_ack outside FETCH: ignored.

Decomposition:
- Package bubble_pkg holds the FSM state enum, LOOP_LENGTH/BOOT_LENGTH defaults and ADDR_W.
- One sub-module, bubble_sync_edge: a 2-FF synchroniser plus rise/fall pulse generator, instantiated per async input.

Test Plan:
- Counter advance: coil_run = 1, bootloader_select = 0, 2053 position_change pulses -> counter steps 0..2052 then wraps to 0. With coil_run = 0, pulses leave the counter unchanged.
- Length switch: counter = 1500, set bootloader_select = 1, one pulse -> counter = 0. Next pulse -> 1.
- Normal read: counter = 37, latch rise -> read_req = 1, read_addr = 37. Ack with data 4'b1010 after 5 cycles -> read_req drops. Strobe fall -> bubble_out = 4'b1010. Notice fall -> bubble_out = 0, busy = 0.
- Underrun: latch rise with ack withheld, strobe fall -> underrun pulse, read_req = 0, bubble_out = 0. A later ack changes nothing.
- Overrun and simultaneous events: latch rise in READY -> overrun pulse, current_position unchanged. Latch and position_change in the same cycle at counter 99 -> current_position = 100.
- Reset in FETCH -> next cycle read_req = 0, busy = 0, counter = 0.
